// File: rtl/frc_dither_if.sv
// Pixel stream into the FRC dithering engine and the dithered subpixel bits out of it.
// The pixel source is the master; the engine is the slave.
interface frc_dither_if #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned IN_BITS  = 5
) ();

  logic                          flm;
  logic                          lp;
  logic [1:0]                    mode;
  logic                          pix_valid;
  logic [CHANNELS*IN_BITS-1:0]   pix_data;
  logic                          out_valid;
  logic [CHANNELS-1:0]           out_data;

  modport master (
    output flm, lp, mode, pix_valid, pix_data,
    input  out_valid, out_data
  );

  modport slave (
    input  flm, lp, mode, pix_valid, pix_data,
    output out_valid, out_data
  );

endinterface

// File: rtl/frc_dither.sv
// Frame-rate-control dither: maps each gray level to one drive bit per subpixel.
// The bit pattern is evenly spread over 2^IN_BITS frames, with optional spatial phase offsets.
module frc_dither #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned IN_BITS  = 5,
  parameter int unsigned X_BITS   = 10,
  parameter int unsigned Y_BITS   = 9,
  parameter int unsigned XK       = 5,
  parameter int unsigned YK       = 3,
  parameter int unsigned CK       = 11
) (
  input  logic         clk,
  input  logic         rst,
  frc_dither_if.slave  bus
);

  localparam int unsigned W = IN_BITS;
  localparam int unsigned C = CHANNELS;

  localparam logic [W-1:0] XK_W = W'(XK);
  localparam logic [W-1:0] YK_W = W'(YK);

  // Frame / line / pixel position trackers
  logic [W-1:0]      frame_cnt;
  logic [X_BITS-1:0] x_cnt;
  logic [Y_BITS-1:0] y_cnt;

  // Position the pixel in this cycle is dithered at (strobes take effect first)
  logic [W-1:0]      f_eff;
  logic [X_BITS-1:0] x_eff;
  logic [Y_BITS-1:0] y_eff;

  logic [W-1:0]        base_ph;
  logic [C-1:0][W-1:0] ph_nxt;

  // Stage 1 pipeline registers
  logic                s1_valid;
  logic [1:0]          s1_mode;
  logic [C-1:0][W-1:0] s1_lvl;
  logic [C-1:0][W-1:0] s1_ph;

  logic [C-1:0] dith;

  // flm wins over lp; both restart the pixel count
  always_comb begin
    f_eff = frame_cnt;
    x_eff = x_cnt;
    y_eff = y_cnt;
    if (bus.flm) begin
      f_eff = frame_cnt + W'(1);
      x_eff = '0;
      y_eff = '0;
    end else if (bus.lp) begin
      y_eff = y_cnt + Y_BITS'(1);
      x_eff = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
    end else begin
      frame_cnt <= f_eff;
      y_cnt     <= y_eff;
      x_cnt     <= bus.pix_valid ? x_eff + X_BITS'(1) : x_eff;
    end
  end

  // Only the low IN_BITS of each position term matter modulo the FRC period
  assign base_ph = f_eff + XK_W * W'(x_eff) + YK_W * W'(y_eff);

  for (genvar c = 0; c < int'(C); c++) begin : g_phase
    localparam logic [W-1:0] CH_OFS = W'(CK * unsigned'(c));
    assign ph_nxt[c] = bus.mode[1] ? base_ph + CH_OFS : f_eff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_lvl   <= '0;
      s1_ph    <= '0;
    end else begin
      s1_valid <= bus.pix_valid;
      if (bus.pix_valid) begin
        s1_mode <= bus.mode;
        s1_lvl  <= bus.pix_data;
        s1_ph   <= ph_nxt;
      end
    end
  end

  // out = carry of (ph*L mod P) + L; full-scale level is forced on since ph = 0 would miss it
  for (genvar c = 0; c < int'(C); c++) begin : g_dither
    logic [W-1:0] prod;
    logic [W:0]   sum;

    assign prod    = s1_ph[c] * s1_lvl[c];
    assign sum     = {1'b0, prod} + {1'b0, s1_lvl[c]};
    assign dith[c] = (s1_mode == 2'b00) ? s1_lvl[c][W-1] :
                     (&s1_lvl[c])       ? 1'b1           :
                                          sum[W];
  end

  // Stage 2: output register holds its value between valid beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_data <= dith;
      end
    end
  end

endmodule

// File: tb/tb_frc_dither.sv
// Directed bench for frc_dither: reset flush, temporal duty, extremes/bypass,
// spatial pattern, strobe collisions and x wrap, all against hand-computed outputs.
module tb_frc_dither;

  localparam int unsigned CH = 3;
  localparam int unsigned IB = 5;
  localparam int unsigned DW = CH * IB;

  logic clk = 1'b0;
  logic rst = 1'b0;

  frc_dither_if #(.CHANNELS(CH), .IN_BITS(IB)) bus ();

  frc_dither #(
    .CHANNELS(CH), .IN_BITS(IB), .X_BITS(10), .Y_BITS(9),
    .XK(5), .YK(3), .CK(11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  string phase = "reset";

  logic [CH-1:0] exp_q[$];
  logic [CH-1:0] last_exp = '0;
  logic [1:0]    vpipe = '0;

  // Hand-derived per-frame bits for levels 1, 8 and 16 in temporal mode (bit i = frame i)
  logic [31:0] v0 = 32'h8000_0000;
  logic [31:0] v1 = 32'h8888_8888;
  logic [31:0] v2 = 32'hAAAA_AAAA;

  logic [CH-1:0] sp_exp [4] = '{3'b010, 3'b101, 3'b010, 3'b101};
  logic [CH-1:0] xw_exp [8] = '{3'b000, 3'b001, 3'b010, 3'b100,
                                3'b000, 3'b000, 3'b000, 3'b000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic f, input logic l, input logic v, input logic [1:0] m,
                      input logic [DW-1:0] d, input logic [CH-1:0] e);
    bus.flm       = f;
    bus.lp        = l;
    bus.pix_valid = v;
    bus.mode      = m;
    bus.pix_data  = d;
    if (v) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.flm       = 1'b0;
    bus.lp        = 1'b0;
    bus.pix_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
  endtask

  // Expected out_valid is the driven pix_valid two edges later
  always @(posedge clk or posedge rst) begin
    if (rst) vpipe <= '0;
    else     vpipe <= {vpipe[0], bus.pix_valid};
  end

  always @(negedge clk) begin
    if (rst) last_exp = '0;
    else if (vpipe[1] && exp_q.size() > 0) last_exp = exp_q.pop_front();
    check({phase, ".valid"}, 32'(bus.out_valid), 32'(vpipe[1]));
    check({phase, ".data"},  32'(bus.out_data),  32'(last_exp));
  end

  initial begin
    bus.flm       = 1'b0;
    bus.lp        = 1'b0;
    bus.mode      = 2'b00;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Pixel in flight when reset hits must never appear
    phase = "flush";
    bus.pix_valid = 1'b1;
    bus.mode      = 2'b01;
    bus.pix_data  = DW'(15'h4101);
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);

    // Temporal: levels {1,8,16}, one pixel per frame, 32 frames
    phase = "temporal";
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'b01, DW'(15'h4101), {v2[i], v1[i], v0[i]});
      step(1'b1, 1'b0, 1'b0, 2'b01, '0, '0);
    end

    // Spatial at f=0 (after wrap), y=0, x=0..3, level 16 on all channels
    phase = "spatial";
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 2'b10, DW'(15'h4210), sp_exp[i]);

    // Extremes and bypass, mode changing per pixel
    phase = "extreme";
    step(1'b0, 1'b0, 1'b1, 2'b01, DW'(15'h03E0), 3'b010);
    step(1'b0, 1'b0, 1'b1, 2'b10, DW'(15'h03E0), 3'b010);
    step(1'b0, 1'b0, 1'b1, 2'b01, DW'(15'h7C1F), 3'b101);
    step(1'b0, 1'b0, 1'b1, 2'b11, DW'(15'h7C1F), 3'b101);
    step(1'b0, 1'b0, 1'b1, 2'b00, DW'(15'h020F), 3'b010);
    step(1'b0, 1'b0, 1'b1, 2'b00, DW'(15'h7DF0), 3'b101);

    // Strobe collisions
    phase = "strobe";
    step(1'b1, 1'b1, 1'b1, 2'b10, DW'(15'h1084), 3'b100);
    step(1'b0, 1'b0, 1'b1, 2'b10, DW'(15'h4210), 3'b010);
    step(1'b0, 1'b1, 1'b1, 2'b10, DW'(15'h1084), 3'b010);
    step(1'b0, 1'b0, 1'b1, 2'b11, DW'(15'h1084), 3'b100);
    step(1'b0, 1'b1, 1'b0, 2'b00, '0, '0);
    step(1'b0, 1'b0, 1'b1, 2'b10, DW'(15'h1084), 3'b001);

    // x wrap: f=1, y=3, 1028 pixels without lp
    phase = "xwrap";
    step(1'b0, 1'b1, 1'b0, 2'b00, '0, '0);
    for (int i = 0; i < 1028; i++) step(1'b0, 1'b0, 1'b1, 2'b10, DW'(15'h1084), xw_exp[i % 8]);

    phase = "drain";
    idle(4);
    check("drain.queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
